// File: rtl/instr_mem_if.sv
// Signal bundle between the instruction memory controller and its three
// neighbours: the fetch stage, the program loader and the physical SRAM.
interface instr_mem_if #(
    parameter int ADR_W   = 64,
    parameter int PHYS_AW = 10
);
    // fetch stage
    logic               f_req;
    logic [ADR_W-1:0]   f_adr;
    logic               f_rsp_rdy;
    logic               f_flush;
    logic               f_gnt;
    logic               f_rsp_vld;
    logic [31:0]        f_instr;
    logic [1:0]         f_fault;
    // program loader
    logic               l_req;
    logic [ADR_W-1:0]   l_adr;
    logic [31:0]        l_wdata;
    logic               l_gnt;
    logic               l_done;
    logic               l_fault;
    // physical SRAM
    logic               m_en;
    logic               m_we;
    logic [PHYS_AW-1:0] m_adr;
    logic [31:0]        m_wdata;
    logic [31:0]        m_rdata;

    // controller side
    modport slave (
        input  f_req, f_adr, f_rsp_rdy, f_flush, l_req, l_adr, l_wdata, m_rdata,
        output f_gnt, f_rsp_vld, f_instr, f_fault, l_gnt, l_done, l_fault,
               m_en, m_we, m_adr, m_wdata
    );

    // requesters and SRAM side
    modport master (
        output f_req, f_adr, f_rsp_rdy, f_flush, l_req, l_adr, l_wdata, m_rdata,
        input  f_gnt, f_rsp_vld, f_instr, f_fault, l_gnt, l_done, l_fault,
               m_en, m_we, m_adr, m_wdata
    );
endinterface

// File: rtl/instr_mem_ctrl.sv
// Instruction SRAM controller: arbitrates fetch reads against loader writes,
// maps core byte addresses into a fixed physical window, reports misaligned
// and out-of-window accesses, and holds each fetch response until accepted.
`ifndef XLEN_64b
`define XLEN_64b 2
`endif
module instr_mem_ctrl #(
    parameter int                             XLEN       = `XLEN_64b,
    parameter int                             PHYS_AW    = 10,
    parameter logic [(1 << (XLEN + 4)) - 1:0] BASE_ADR   = '0,
    parameter int                             STARVE_MAX = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    instr_mem_if.slave bus,
    output logic       o_busy
);
    localparam int              ADR_W  = 1 << (XLEN + 4);
    localparam int              SC_W   = $clog2(STARVE_MAX + 1);
    localparam logic [SC_W-1:0] SC_TOP = SC_W'(STARVE_MAX);
    localparam logic [31:0]     NOP    = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, RD_CAP, RSP, WR_DONE} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [SC_W-1:0] r_starve_cnt;
    logic [31:0]     r_f_instr;
    logic [1:0]      r_f_fault;
    logic            r_l_fault;

    logic [1:0]      w_f_fault;
    logic            w_l_bad;
    logic            w_idle;
    logic            w_l_win;
    logic            w_f_gnt;
    logic            w_l_gnt;

    // Fault code for a byte address; misalignment is reported ahead of range.
    function automatic logic [1:0] fault_of(input logic [ADR_W-1:0] adr);
        if (adr[1:0] != 2'b00)
            return 2'b01;
        if ((adr < BASE_ADR) || (((adr - BASE_ADR) >> (PHYS_AW + 2)) != '0))
            return 2'b10;
        return 2'b00;
    endfunction

    // Word index inside the window (only meaningful for fault-free addresses).
    function automatic logic [PHYS_AW-1:0] phys_idx(input logic [ADR_W-1:0] adr);
        return PHYS_AW'((adr - BASE_ADR) >> 2);
    endfunction

    assign bus.f_rsp_vld = (r_state == RSP) && !bus.f_flush;
    assign bus.f_instr   = r_f_instr;
    assign bus.f_fault   = r_f_fault;
    assign bus.l_done    = (r_state == WR_DONE);
    assign bus.l_fault   = (r_state == WR_DONE) && r_l_fault;
    assign o_busy        = (r_state != IDLE);

    // Arbitration, SRAM command and next-state decode.
    always_comb begin
        w_state_next = r_state;
        w_f_fault    = fault_of(bus.f_adr);
        w_l_bad      = (fault_of(bus.l_adr) != 2'b00);
        // grants are suppressed while reset is held so nothing leaks out
        w_idle       = (r_state == IDLE) && !i_rst;
        w_l_win      = bus.l_req && (!bus.f_req || (r_starve_cnt == SC_TOP));
        w_f_gnt      = w_idle && bus.f_req && !w_l_win;
        w_l_gnt      = w_idle && w_l_win;
        bus.f_gnt    = w_f_gnt;
        bus.l_gnt    = w_l_gnt;
        bus.m_en     = 1'b0;
        bus.m_we     = 1'b0;
        bus.m_adr    = '0;
        bus.m_wdata  = '0;

        if (w_f_gnt && (w_f_fault == 2'b00)) begin
            bus.m_en  = 1'b1;
            bus.m_adr = phys_idx(bus.f_adr);
        end else if (w_l_gnt && !w_l_bad) begin
            bus.m_en    = 1'b1;
            bus.m_we    = 1'b1;
            bus.m_adr   = phys_idx(bus.l_adr);
            bus.m_wdata = bus.l_wdata;
        end

        case (r_state)
            IDLE: begin
                if (w_f_gnt)
                    w_state_next = (w_f_fault == 2'b00) ? RD_CAP : RSP;
                else if (w_l_gnt)
                    w_state_next = WR_DONE;
            end
            RD_CAP:  w_state_next = bus.f_flush ? IDLE : RSP;
            // flush drops the response; otherwise leave once it is accepted
            RSP:     if (bus.f_flush || bus.f_rsp_rdy) w_state_next = IDLE;
            WR_DONE: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    // Count fetch grants won while the loader waits; it wins once saturated.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_starve_cnt <= '0;
        else if (!bus.l_req || w_l_gnt)
            r_starve_cnt <= '0;
        else if (w_f_gnt && (r_starve_cnt != SC_TOP))
            r_starve_cnt <= r_starve_cnt + 1'b1;
    end

    // Response holding registers: fault/NOP at grant, SRAM word in RD_CAP.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_f_instr <= '0;
            r_f_fault <= '0;
            r_l_fault <= 1'b0;
        end else begin
            if (w_f_gnt) begin
                r_f_fault <= w_f_fault;
                if (w_f_fault != 2'b00)
                    r_f_instr <= NOP;
            end
            if (r_state == RD_CAP)
                r_f_instr <= bus.m_rdata;
            if (w_l_gnt)
                r_l_fault <= w_l_bad;
        end
    end
endmodule
